// File: rtl/gnpu_pkg.sv
// gnpu_pkg: width defaults and shared helpers for the scratchpad arbiter slice.
// Width macros may be overridden on the command line; these are fallbacks.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef SARRAY_LOAD_WIDTH
`define SARRAY_LOAD_WIDTH 32
`endif
`ifndef SARRAY_STORE_WIDTH
`define SARRAY_STORE_WIDTH 32
`endif

package gnpu_pkg;
    localparam int ADDR_W_DEF = `ADDR_WIDTH;
    localparam int LOAD_W_DEF = `SARRAY_LOAD_WIDTH;
    localparam int STORE_W_DEF = `SARRAY_STORE_WIDTH;

    typedef enum logic {ARB_OPEN, ARB_HOLD} arb_st_e;

    // A single channel still needs one bit to carry its (constant) index.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/spad_arb_if.sv
// spad_arb_if: requester-side and scratchpad-side handshakes of spad_arb.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface spad_arb_if #(
    parameter int NCH = 2,
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int RD_W = `SARRAY_LOAD_WIDTH,
    parameter int WR_W = `SARRAY_STORE_WIDTH
);
    logic [NCH-1:0] req_ar_valid_i, req_ar_ready_o;
    logic [NCH*ADDR_W-1:0] req_ar_addr_i;
    logic [NCH-1:0] req_r_valid_o, req_r_ready_i;
    logic [RD_W-1:0] req_r_data_o;
    logic [NCH-1:0] req_aw_valid_i, req_aw_ready_o;
    logic [NCH*ADDR_W-1:0] req_aw_addr_i;
    logic [NCH*WR_W-1:0] req_aw_data_i;
    logic spad_ar_valid_o, spad_ar_ready_i;
    logic [ADDR_W-1:0] spad_ar_addr_o;
    logic spad_r_valid_i, spad_r_ready_o;
    logic [RD_W-1:0] spad_r_data_i;
    logic spad_aw_valid_o, spad_aw_ready_i;
    logic [ADDR_W-1:0] spad_aw_addr_o;
    logic [WR_W-1:0] spad_aw_data_o;

    modport slave (
        input req_ar_valid_i, req_ar_addr_i, req_r_ready_i, req_aw_valid_i, req_aw_addr_i,
              req_aw_data_i, spad_ar_ready_i, spad_r_valid_i, spad_r_data_i, spad_aw_ready_i,
        output req_ar_ready_o, req_r_valid_o, req_r_data_o, req_aw_ready_o, spad_ar_valid_o,
               spad_ar_addr_o, spad_r_ready_o, spad_aw_valid_o, spad_aw_addr_o, spad_aw_data_o
    );
    modport master (
        output req_ar_valid_i, req_ar_addr_i, req_r_ready_i, req_aw_valid_i, req_aw_addr_i,
               req_aw_data_i, spad_ar_ready_i, spad_r_valid_i, spad_r_data_i, spad_aw_ready_i,
        input req_ar_ready_o, req_r_valid_o, req_r_data_o, req_aw_ready_o, spad_ar_valid_o,
              spad_ar_addr_o, spad_r_ready_o, spad_aw_valid_o, spad_aw_addr_o, spad_aw_data_o
    );
endinterface

// File: rtl/spad_arb_id_fifo.sv
// spad_arb_id_fifo: in-order channel-ID queue for outstanding reads.
module spad_arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic full,
    output logic empty,
    output logic [AW:0] cnt
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp_q, rp_q;
    logic do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop) rp_q <= rp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) if (do_push) mem[wp_q[AW-1:0]] <= din;

    assign cnt = wp_q - rp_q;
    assign full = cnt == (AW + 1)'(DEPTH);
    assign empty = wp_q == rp_q;
    assign head = mem[rp_q[AW-1:0]];
endmodule

// File: rtl/spad_arb_rr.sv
// spad_arb_rr: round-robin arbiter with grant hold while the winner waits for ready.
module spad_arb_rr import gnpu_pkg::*; #(
    parameter int NCH = 2,
    localparam int IW = id_w(NCH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [NCH-1:0] req,
    input  logic en,
    input  logic ready,
    output logic valid,
    output logic [IW-1:0] grant
);
    arb_st_e st_q, st_d;
    logic [IW-1:0] ptr_q, ptr_d, hold_q, hold_d, pick, j;
    logic hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= ARB_OPEN;
            ptr_q <= '0;
            hold_q <= '0;
        end else begin
            st_q <= st_d;
            ptr_q <= ptr_d;
            hold_q <= hold_d;
        end
    end

    // Walk downward so the requester closest to the pointer wins.
    always_comb begin
        pick = ptr_q;
        j = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            j = IW'((int'(ptr_q) + i) % NCH);
            if (req[j]) pick = j;
        end
    end

    always_comb begin
        st_d = st_q;
        ptr_d = ptr_q;
        hold_d = hold_q;
        if (hs) begin
            st_d = ARB_OPEN;
            ptr_d = (grant == IW'(NCH - 1)) ? '0 : grant + 1'b1;
        end else if (valid) begin
            st_d = ARB_HOLD;
            hold_d = grant;
        end
    end

    always_comb begin
        grant = (st_q == ARB_HOLD) ? hold_q : pick;
        valid = en && req[grant];
    end

    assign hs = valid && ready;
endmodule

// File: rtl/spad_arb.sv
// spad_arb: NCH-channel round-robin arbiter onto one scratchpad port, in-order reads.
// Define GNPU_ARB_PERF_EN to build the saturating AR stall counter.
module spad_arb import gnpu_pkg::*; #(
    parameter int NCH = 2,
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int RD_W = `SARRAY_LOAD_WIDTH,
    parameter int WR_W = `SARRAY_STORE_WIDTH,
    parameter int OT_DEPTH = 4,
    localparam int IW = id_w(NCH),
    localparam int CW = $clog2(OT_DEPTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    spad_arb_if.slave bus,
    output logic [CW-1:0] ot_cnt_o,
    output logic r_err_o,
    output logic [31:0] ar_stall_cnt_o
);
    logic ar_valid, aw_valid, ar_hs, aw_hs, r_pop, full, empty;
    logic [IW-1:0] ar_gnt, aw_gnt, head;

    // rst_n in the enables keeps every valid low while reset is held.
    spad_arb_rr #(.NCH(NCH)) u_ar (
        .clk(clk), .rst_n(rst_n), .req(bus.req_ar_valid_i), .en(rst_n && !full),
        .ready(bus.spad_ar_ready_i), .valid(ar_valid), .grant(ar_gnt)
    );
    spad_arb_rr #(.NCH(NCH)) u_aw (
        .clk(clk), .rst_n(rst_n), .req(bus.req_aw_valid_i), .en(rst_n),
        .ready(bus.spad_aw_ready_i), .valid(aw_valid), .grant(aw_gnt)
    );
    spad_arb_id_fifo #(.DEPTH(OT_DEPTH), .W(IW)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(ar_hs), .pop(r_pop), .din(ar_gnt),
        .head(head), .full(full), .empty(empty), .cnt(ot_cnt_o)
    );

    assign ar_hs = ar_valid && bus.spad_ar_ready_i;
    assign aw_hs = aw_valid && bus.spad_aw_ready_i;

    assign bus.spad_ar_valid_o = ar_valid;
    assign bus.spad_ar_addr_o = bus.req_ar_addr_i[int'(ar_gnt) * ADDR_W +: ADDR_W];
    assign bus.req_ar_ready_o = ar_hs ? NCH'(1) << ar_gnt : '0;

    assign bus.spad_aw_valid_o = aw_valid;
    assign bus.spad_aw_addr_o = bus.req_aw_addr_i[int'(aw_gnt) * ADDR_W +: ADDR_W];
    assign bus.spad_aw_data_o = bus.req_aw_data_i[int'(aw_gnt) * WR_W +: WR_W];
    assign bus.req_aw_ready_o = aw_hs ? NCH'(1) << aw_gnt : '0;

    // An unexpected beat is accepted and dropped so the scratchpad never stalls.
    assign bus.req_r_valid_o = (bus.spad_r_valid_i && !empty) ? NCH'(1) << head : '0;
    assign bus.spad_r_ready_o = empty || bus.req_r_ready_i[head];
    assign bus.req_r_data_o = bus.spad_r_data_i;
    assign r_pop = bus.spad_r_valid_i && bus.spad_r_ready_o && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err_o <= 1'b0;
        else if (bus.spad_r_valid_i && empty) r_err_o <= 1'b1;
    end

`ifdef GNPU_ARB_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else if (|bus.req_ar_valid_i && !ar_hs && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
    assign ar_stall_cnt_o = stall_q;
`else
    assign ar_stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_spad_arb.sv
// tb_spad_arb: directed checks of arbitration, hold, in-order return, reset and error flag.
module tb_spad_arb;
    localparam int NCH = 2, AW = 16, RW = 32, WW = 32, OT = 4;
`ifdef GNPU_ARB_PERF_EN
    localparam int STALL_EXP = 5;
`else
    localparam int STALL_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] ot_cnt;
    logic r_err;
    logic [31:0] stall;
    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spad_arb_if #(.NCH(NCH), .ADDR_W(AW), .RD_W(RW), .WR_W(WW)) bus ();

    spad_arb #(.NCH(NCH), .ADDR_W(AW), .RD_W(RW), .WR_W(WW), .OT_DEPTH(OT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ot_cnt_o(ot_cnt), .r_err_o(r_err), .ar_stall_cnt_o(stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_ar_valid_i = 2'b11;
        bus.req_ar_addr_i = {16'h0200, 16'h0100};
        bus.req_r_ready_i = 2'b00;
        bus.req_aw_valid_i = 2'b11;
        bus.req_aw_addr_i = {16'h0400, 16'h0300};
        bus.req_aw_data_i = {32'h000000B1, 32'h000000A0};
        bus.spad_ar_ready_i = 1'b1;
        bus.spad_r_valid_i = 1'b0;
        bus.spad_r_data_i = '0;
        bus.spad_aw_ready_i = 1'b1;
        tick;
        tick;
        check("rst_ar_valid", bus.spad_ar_valid_o, 0);
        check("rst_aw_valid", bus.spad_aw_valid_o, 0);
        check("rst_ar_ready", bus.req_ar_ready_o, 0);
        check("rst_r_valid", bus.req_r_valid_o, 0);
        check("rst_ot", ot_cnt, 0);
        check("rst_err", r_err, 0);
        check("rst_stall", stall, 0);
        rst_n = 1'b1;
        bus.req_ar_valid_i = 2'b00;

        for (int i = 0; i < 3; i++) begin
            #1;
            check("aw_valid", bus.spad_aw_valid_o, 1);
            check("aw_addr", bus.spad_aw_addr_o, (i % 2) ? 16'h0400 : 16'h0300);
            check("aw_data", bus.spad_aw_data_o, (i % 2) ? 32'hB1 : 32'hA0);
            check("aw_ready", bus.req_aw_ready_o, (i % 2) ? 2'b10 : 2'b01);
            tick;
        end
        bus.spad_aw_ready_i = 1'b0;
        #1;
        check("aw_wait_addr", bus.spad_aw_addr_o, 16'h0400);
        check("aw_wait_ready", bus.req_aw_ready_o, 2'b00);
        bus.req_aw_valid_i = 2'b00;
        tick;

        bus.req_ar_valid_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("ar_alt_valid", bus.spad_ar_valid_o, 1);
            check("ar_alt_addr", bus.spad_ar_addr_o, (i % 2) ? 16'h0200 : 16'h0100);
            check("ar_alt_ready", bus.req_ar_ready_o, (i % 2) ? 2'b10 : 2'b01);
            tick;
        end
        #1;
        check("full_ot", ot_cnt, 4);
        check("full_ar_valid", bus.spad_ar_valid_o, 0);
        bus.spad_r_valid_i = 1'b1;
        bus.spad_r_data_i = 32'hD0;
        bus.req_r_ready_i = 2'b10;
        #1;
        check("r_bp_ready", bus.spad_r_ready_o, 0);
        check("r_bp_valid", bus.req_r_valid_o, 2'b01);
        check("r_data", bus.req_r_data_o, 32'hD0);
        tick;
        check("r_bp_ot", ot_cnt, 4);
        bus.req_r_ready_i = 2'b11;
        #1;
        check("r_pop_ready", bus.spad_r_ready_o, 1);
        check("full_pop_ar_valid", bus.spad_ar_valid_o, 0);
        tick;
        #1;
        check("pop_ot", ot_cnt, 3);
        check("reopen_ar_valid", bus.spad_ar_valid_o, 1);
        check("reopen_ar_addr", bus.spad_ar_addr_o, 16'h0100);
        check("r_head1", bus.req_r_valid_o, 2'b10);
        tick;
        check("pushpop_ot", ot_cnt, 3);
        bus.req_ar_valid_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("drain_valid", bus.req_r_valid_o, (i == 1) ? 2'b10 : 2'b01);
            tick;
        end
        check("drain_ot", ot_cnt, 0);
        bus.spad_r_valid_i = 1'b0;

        bus.req_ar_valid_i = 2'b10;
        #1;
        check("ch1_addr", bus.spad_ar_addr_o, 16'h0200);
        check("ch1_ready", bus.req_ar_ready_o, 2'b10);
        tick;
        bus.spad_ar_ready_i = 1'b0;
        #1;
        check("hold_valid", bus.spad_ar_valid_o, 1);
        check("hold_addr0", bus.spad_ar_addr_o, 16'h0200);
        check("hold_ready0", bus.req_ar_ready_o, 2'b00);
        tick;
        bus.req_ar_valid_i = 2'b11;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("hold_addr", bus.spad_ar_addr_o, 16'h0200);
            tick;
        end
        bus.spad_ar_ready_i = 1'b1;
        #1;
        check("hold_hs_addr", bus.spad_ar_addr_o, 16'h0200);
        check("hold_hs_ready", bus.req_ar_ready_o, 2'b10);
        tick;
        #1;
        check("after_hold_addr", bus.spad_ar_addr_o, 16'h0100);
        check("after_hold_ready", bus.req_ar_ready_o, 2'b01);
        check("two_ot", ot_cnt, 2);
        bus.spad_ar_ready_i = 1'b0;
        tick;

        rst_n = 1'b0;
        #1;
        check("midrst_ot", ot_cnt, 0);
        check("midrst_ar_valid", bus.spad_ar_valid_o, 0);
        tick;
        rst_n = 1'b1;
        #1;
        check("postrst_ptr_addr", bus.spad_ar_addr_o, 16'h0100);
        check("postrst_valid", bus.spad_ar_valid_o, 1);
        bus.req_ar_valid_i = 2'b10;
        bus.spad_ar_ready_i = 1'b1;
        #1;
        check("postrst_ch1_addr", bus.spad_ar_addr_o, 16'h0200);
        check("postrst_ch1_ready", bus.req_ar_ready_o, 2'b10);
        tick;
        check("postrst_ot", ot_cnt, 1);
        bus.req_ar_valid_i = 2'b00;

        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        bus.req_ar_valid_i = 2'b01;
        bus.spad_ar_ready_i = 1'b0;
        repeat (5) tick;
        check("stall_cnt", stall, STALL_EXP);
        bus.req_ar_valid_i = 2'b00;

        bus.spad_r_valid_i = 1'b1;
        bus.req_r_ready_i = 2'b00;
        #1;
        check("orphan_ready", bus.spad_r_ready_o, 1);
        check("orphan_valid", bus.req_r_valid_o, 2'b00);
        tick;
        bus.spad_r_valid_i = 1'b0;
        check("err_set", r_err, 1);
        check("err_ot", ot_cnt, 0);
        tick;
        tick;
        check("err_held", r_err, 1);
        rst_n = 1'b0;
        #1;
        check("err_clr", r_err, 0);
        check("stall_clr", stall, 0);
        tick;
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/spad_arb.md
SPAD_ARB -- requirements
Module: spad_arb

Interface
REQ-001 Parameter NCH, default 2: number of requester channels (systolic arrays), 1..8.
REQ-002 Parameter ADDR_W, default `ADDR_WIDTH: address width.
REQ-003 Parameter RD_W, default `SARRAY_LOAD_WIDTH: read data width.
REQ-004 Parameter WR_W, default `SARRAY_STORE_WIDTH: write data width.
REQ-005 Parameter OT_DEPTH, default 4: maximum outstanding reads, power of two.
REQ-006 clk  in  1  single clock.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 req_ar_valid_i / req_ar_ready_o  in/out  NCH  per-channel read-address handshake.
REQ-009 req_ar_addr_i  in  NCH*ADDR_W  per-channel read address, channel k in bits [k*ADDR_W +: ADDR_W].
REQ-010 req_r_valid_o / req_r_ready_i  out/in  NCH  per-channel read-data handshake.
REQ-011 req_r_data_o  out  RD_W  read data, broadcast to all channels.
REQ-012 req_aw_valid_i / req_aw_ready_o  in/out  NCH  per-channel write handshake.
REQ-013 req_aw_addr_i / req_aw_data_i  in  NCH*ADDR_W / NCH*WR_W  per-channel write address and data.
REQ-014 spad_ar_valid_o, spad_ar_ready_i, spad_ar_addr_o  out/in/out  1/1/ADDR_W  scratchpad read-address port.
REQ-015 spad_r_valid_i, spad_r_ready_o, spad_r_data_i  in/out/in  1/1/RD_W  scratchpad read-data port.
REQ-016 spad_aw_valid_o, spad_aw_ready_i, spad_aw_addr_o, spad_aw_data_o  out/in/out/out  1/1/ADDR_W/WR_W  scratchpad write port.
REQ-017 ot_cnt_o  out  $clog2(OT_DEPTH)+1  number of outstanding reads.
REQ-018 r_err_o  out  1  sticky flag: spad read data arrived with no read outstanding.
REQ-019 ar_stall_cnt_o  out  32  read-stall performance counter.

Function
REQ-020 Read and write arbiters SHALL operate independently, each round-robin; the request path is combinational (zero-cycle latency from winning valid to spad valid).
REQ-021 Round-robin: search starts at pointer P; after an accepted handshake on channel k, P SHALL become (k+1) mod NCH.
REQ-022 Once spad_ar_valid_o is high without spad_ar_ready_i, the grant SHALL be locked to that channel until the handshake completes; same rule for AW.
REQ-023 spad_ar_valid_o SHALL be low while the ID FIFO is full, even if a pop happens in the same cycle.
REQ-024 Each accepted AR handshake SHALL push the granted channel index into the ID FIFO.
REQ-025 Read data SHALL return in order: FIFO head selects the channel; req_r_valid_o[head] = spad_r_valid_i; spad_r_ready_o = req_r_ready_i[head]; the head entry is popped on the spad R handshake.
REQ-026 spad_r_valid_i with an empty FIFO SHALL keep spad_r_ready_o high (drop the beat) and set r_err_o until reset.
REQ-027 req_*_ready_o SHALL be high only for the granted channel, and only when the spad side is ready.
REQ-028 Writes have no response; an AW handshake completes the transaction.
REQ-029 Simultaneous push and pop on a non-full FIFO SHALL leave ot_cnt_o unchanged.

Reset
REQ-030 Asserting rst_n low SHALL, mid-operation included, clear both RR pointers to 0, empty the FIFO, clear locks, ot_cnt_o, r_err_o and ar_stall_cnt_o; all valid outputs read 0 during reset.

Configuration
REQ-031 With GNPU_ARB_PERF_EN defined, ar_stall_cnt_o SHALL increment (saturating) on each cycle in which any req_ar_valid_i is high and no AR handshake occurs.
REQ-032 Without GNPU_ARB_PERF_EN, ar_stall_cnt_o SHALL be tied to 0 and no counter flop is built.

Structure
REQ-033 gnpu_pkg SHALL hold ADDR/load/store width constants and the channel-ID width function; the RR arbiter is reused for AR and AW.
REQ-034 The ID FIFO SHALL be the sub-module spad_arb_id_fifo (depth OT_DEPTH, width $clog2(NCH)).

Verification
REQ-035 NCH=2, both channels raise AR every cycle, spad always ready -> grants alternate 0,1,0,1; R data routes to matching channels in order.
REQ-036 Channel 1 AR with spad_ar_ready_i low for 3 cycles while channel 0 rises -> grant stays 1 until the handshake, then goes to 0.
REQ-037 Four reads issued, no R returned, OT_DEPTH=4 -> ot_cnt_o=4, spad_ar_valid_o low; one R returned -> next AR accepted the cycle after.
REQ-038 spad_r_valid_i pulse with FIFO empty -> r_err_o=1, held until reset; ot_cnt_o stays 0.
REQ-039 rst_n low with 2 reads outstanding -> ot_cnt_o=0, pointers 0; the first post-reset request from channel 1 alone is granted.
REQ-040 With GNPU_ARB_PERF_EN, channel 0 valid for 5 cycles with spad_ar_ready_i low -> ar_stall_cnt_o=5.
